// File: rtl/stack_id_pkg.sv
// Shared types and frame layout helpers for 3D-stack die ID enumeration.
package stack_id_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_ID    = 3'd1,
    S_TX       = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  localparam logic [3:0]  FRAME_HDR = 4'hA;
  localparam int unsigned SYNC_W    = 16;

  // Field offsets: sync | src id | dst id | power | header
  function automatic int unsigned src_lsb();
    return SYNC_W;
  endfunction

  function automatic int unsigned dst_lsb(input int unsigned id_w);
    return SYNC_W + id_w;
  endfunction

  function automatic int unsigned pwr_lsb(input int unsigned id_w);
    return SYNC_W + 2 * id_w;
  endfunction

  function automatic int unsigned hdr_lsb(input int unsigned id_w, input int unsigned pwr_w);
    return SYNC_W + 2 * id_w + pwr_w;
  endfunction

endpackage

// File: rtl/stack_id_enum_if.sv
// Inter-die frame link: receive path plus valid/ready transmit path.
interface stack_id_enum_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              rx_valid;
  logic [DATA_W-1:0] data_in;
  logic              tx_ready;
  logic              tx_valid;
  logic [DATA_W-1:0] data_out;

  // master: link side feeding the enumerator; slave: the enumerator itself
  modport master (
    output rx_valid, data_in, tx_ready,
    input  tx_valid, data_out
  );

  modport slave (
    input  rx_valid, data_in, tx_ready,
    output tx_valid, data_out
  );

endinterface

// File: rtl/stack_id_timer.sv
// Clearable ack-wait cycle counter with terminal count at TIMEOUT-1.
module stack_id_timer #(
  parameter int unsigned TIMEOUT = 20
) (
  input  logic div_8_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  assign tc_c = (count_q == CNT_W'(TIMEOUT - 1));

  // Counter parks at terminal count until cleared
  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !tc_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stack_id_enum.sv
// Die ID enumeration for a TSV stack: receive own ID from below, announce the
// next ID upward with ramping drive power, and detect top-of-stack or conflicts.
module stack_id_enum
  import stack_id_pkg::*;
#(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned PWR_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 20,
  parameter logic [15:0] SYNC    = 16'hBEEF
) (
  input  logic             div_8_clk,
  input  logic             rst_n,
  input  logic             f_layer,
  input  logic             restart,
  stack_id_enum_if.slave   bus,
  output logic [ID_W-1:0]  chip_id,
  output logic [PWR_W-1:0] power_value,
  output logic [PWR_W-1:0] retry_cnt,
  output logic             sort_finish,
  output logic             is_top,
  output logic             sort_fail
);

  localparam int unsigned SRC_LSB = src_lsb();
  localparam int unsigned DST_LSB = dst_lsb(ID_W);
  localparam int unsigned PWR_LSB = pwr_lsb(ID_W);
  localparam int unsigned HDR_LSB = hdr_lsb(ID_W, PWR_W);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   chip_id_d;
  logic [PWR_W-1:0]  power_d;
  logic [PWR_W-1:0]  retry_d;
  logic              is_top_d;
  logic              enter_tx;
  logic              tx_valid_q;
  logic [DATA_W-1:0] data_out_q;

  logic              rx_match;
  logic [ID_W-1:0]   rx_src;
  logic [ID_W-1:0]   rx_dst;
  logic [ID_W-1:0]   id_next;
  logic              tmr_en;
  logic              tmr_clr;
  logic              tmr_tc;
  logic              unused_rx_bits;

  function automatic logic [DATA_W-1:0] build_frame(input logic [ID_W-1:0]  id,
                                                    input logic [PWR_W-1:0] pwr);
    logic [DATA_W-1:0] f;
    f                    = '0;
    f[SYNC_W-1:0]        = SYNC;
    f[SRC_LSB +: ID_W]   = id;
    f[DST_LSB +: ID_W]   = id + ID_W'(1);
    f[PWR_LSB +: PWR_W]  = pwr;
    f[HDR_LSB +: 4]      = FRAME_HDR;
    return f;
  endfunction

  assign rx_match       = bus.rx_valid && (bus.data_in[SYNC_W-1:0] == SYNC);
  assign rx_src         = bus.data_in[SRC_LSB +: ID_W];
  assign rx_dst         = bus.data_in[DST_LSB +: ID_W];
  assign id_next        = chip_id + ID_W'(1);
  assign unused_rx_bits = ^bus.data_in;

  assign tmr_en  = (state_q == S_WAIT_ACK);
  assign tmr_clr = (state_q != S_WAIT_ACK);

  stack_id_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .div_8_clk (div_8_clk),
    .rst_n     (rst_n),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .tc_c      (tmr_tc)
  );

  // Next-state and next-register values
  always_comb begin
    state_d   = state_q;
    chip_id_d = chip_id;
    power_d   = power_value;
    retry_d   = retry_cnt;
    is_top_d  = is_top;
    enter_tx  = 1'b0;

    if (restart) begin
      state_d   = S_IDLE;
      chip_id_d = '0;
      power_d   = '0;
      retry_d   = '0;
      is_top_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (f_layer) begin
            chip_id_d = ID_W'(1);
            enter_tx  = 1'b1;
          end else begin
            state_d = S_RX_ID;
          end
        end
        S_RX_ID: begin
          if (rx_match) begin
            chip_id_d = rx_dst;
            if ((rx_dst == '0) || (rx_dst == '1)) state_d = S_FAIL;
            else                                  enter_tx = 1'b1;
          end
        end
        S_TX: begin
          if (bus.tx_ready) state_d = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // A frame arriving on the terminal cycle wins over the timeout
          if (rx_match) begin
            if (rx_src == id_next) begin
              state_d  = S_DONE;
              is_top_d = 1'b0;
            end else begin
              state_d = S_FAIL;
            end
          end else if (tmr_tc) begin
            if (power_value == '1) begin
              state_d  = S_DONE;
              is_top_d = 1'b1;
            end else begin
              if (retry_cnt != '1) retry_d = retry_cnt + PWR_W'(1);
              enter_tx = 1'b1;
            end
          end
        end
        S_DONE, S_FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // An all-ones ID has no successor to announce
      if (enter_tx) begin
        if (chip_id_d == '1) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_TX;
          if (power_value != '1) power_d = power_value + PWR_W'(1);
        end
      end
    end
  end

  // State and registered outputs, decoded from next state
  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      chip_id     <= '0;
      power_value <= '0;
      retry_cnt   <= '0;
      is_top      <= 1'b0;
      sort_finish <= 1'b0;
      sort_fail   <= 1'b0;
      tx_valid_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      chip_id     <= chip_id_d;
      power_value <= power_d;
      retry_cnt   <= retry_d;
      is_top      <= is_top_d;
      sort_finish <= (state_d == S_DONE);
      sort_fail   <= (state_d == S_FAIL);
      tx_valid_q  <= (state_d == S_TX);
      data_out_q  <= (state_d == S_TX) ? build_frame(chip_id_d, power_d) : '0;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_stack_id_enum.sv
// Directed bench for stack_id_enum: bottom/middle die enumeration, retries,
// conflicts, stalls, restart and mid-operation reset.
module tb_stack_id_enum;

  logic       div_8_clk = 1'b0;
  logic       rst_n;
  logic       f_layer;
  logic       restart;
  logic [3:0] chip_id;
  logic [3:0] power_value;
  logic [3:0] retry_cnt;
  logic       sort_finish;
  logic       is_top;
  logic       sort_fail;

  int checks = 0;
  int errors = 0;

  stack_id_enum_if #(.DATA_W(32)) bus ();

  stack_id_enum #(
    .ID_W    (4),
    .PWR_W   (4),
    .DATA_W  (32),
    .TIMEOUT (20),
    .SYNC    (16'hBEEF)
  ) dut (
    .div_8_clk   (div_8_clk),
    .rst_n       (rst_n),
    .f_layer     (f_layer),
    .restart     (restart),
    .bus         (bus),
    .chip_id     (chip_id),
    .power_value (power_value),
    .retry_cnt   (retry_cnt),
    .sort_finish (sort_finish),
    .is_top      (is_top),
    .sort_fail   (sort_fail)
  );

  always #5 div_8_clk = ~div_8_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge div_8_clk);
      #1;
    end
  endtask

  task automatic rx(input logic v, input logic [31:0] d);
    bus.rx_valid = v;
    bus.data_in  = d;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_chip_id"}, 32'(chip_id), 32'h0);
    check({tag, "_power"},   32'(power_value), 32'h0);
    check({tag, "_retry"},   32'(retry_cnt), 32'h0);
    check({tag, "_flags"},   {29'h0, sort_finish, is_top, sort_fail}, 32'h0);
    check({tag, "_tx"},      {31'h0, bus.tx_valid}, 32'h0);
    check({tag, "_data"},    bus.data_out, 32'h0);
  endtask

  int          n_tx;
  int          gap;
  int          first_gap;
  int          gap_errs;
  int          budget;
  logic [31:0] last_frame;

  initial begin
    rst_n        = 1'b0;
    f_layer      = 1'b1;
    restart      = 1'b0;
    bus.tx_ready = 1'b1;
    rx(1'b0, 32'h0);
    tick(2);
    check_cleared("reset");

    // Bottom die: ID 1, ack from die 2 on the third wait cycle
    rst_n = 1'b1;
    tick();
    check("b_tx_valid", {31'h0, bus.tx_valid}, 32'h1);
    check("b_frame", bus.data_out, 32'hA121BEEF);
    check("b_chip_id", 32'(chip_id), 32'h1);
    check("b_power", 32'(power_value), 32'h1);
    tick();
    check("b_wait_tx_off", {31'h0, bus.tx_valid}, 32'h0);
    check("b_wait_data_off", bus.data_out, 32'h0);
    tick(2);
    rx(1'b1, 32'h0002BEEF);
    tick();
    rx(1'b0, 32'h0);
    check("b_finish", {31'h0, sort_finish}, 32'h1);
    check("b_is_top", {31'h0, is_top}, 32'h0);
    check("b_fail", {31'h0, sort_fail}, 32'h0);

    // Restart from DONE clears everything
    restart = 1'b1;
    f_layer = 1'b0;
    tick();
    restart = 1'b0;
    check_cleared("restart");

    // Middle die: wrong sync ignored, then assigned ID 3
    tick();
    rx(1'b1, 32'h0030DEAD);
    tick();
    check("m_badsync_tx", {31'h0, bus.tx_valid}, 32'h0);
    check("m_badsync_id", 32'(chip_id), 32'h0);
    rx(1'b1, 32'h0030BEEF);
    bus.tx_ready = 1'b0;
    tick();
    rx(1'b1, 32'h0004BEEF);
    check("m_chip_id", 32'(chip_id), 32'h3);
    check("m_power", 32'(power_value), 32'h1);
    check("m_frame", bus.data_out, 32'hA143BEEF);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("m_stall_frame", bus.data_out, 32'hA143BEEF);
      check("m_stall_valid", {31'h0, bus.tx_valid}, 32'h1);
    end
    rx(1'b0, 32'h0);
    bus.tx_ready = 1'b1;
    tick();
    check("m_wait_tx_off", {31'h0, bus.tx_valid}, 32'h0);
    tick(19);
    check("m_pre_to_finish", {31'h0, sort_finish}, 32'h0);
    check("m_pre_to_tx", {31'h0, bus.tx_valid}, 32'h0);
    rx(1'b1, 32'h0004BEEF);
    tick();
    rx(1'b0, 32'h0);
    check("m_coincident_finish", {31'h0, sort_finish}, 32'h1);
    check("m_coincident_top", {31'h0, is_top}, 32'h0);
    check("m_coincident_retry", 32'(retry_cnt), 32'h0);

    // Top die: no ack ever, ramp power to max then declare top
    restart = 1'b1;
    f_layer = 1'b1;
    tick();
    restart = 1'b0;
    n_tx = 0; gap = 0; first_gap = -1; gap_errs = 0; budget = 0;
    last_frame = 32'h0;
    while (!(sort_finish || sort_fail) && budget < 1000) begin
      tick();
      budget++;
      if (bus.tx_valid) begin
        if (n_tx > 0) begin
          if (first_gap < 0) first_gap = gap;
          if (gap != 20) gap_errs++;
        end
        n_tx++;
        gap = 0;
        last_frame = bus.data_out;
      end else begin
        gap++;
      end
    end
    check("t_in_budget", {31'h0, sort_finish || sort_fail}, 32'h1);
    check("t_attempts", 32'(n_tx), 32'd15);
    check("t_first_gap", 32'(first_gap), 32'd20);
    check("t_gap_errs", 32'(gap_errs), 32'd0);
    check("t_last_frame", last_frame, 32'hAF21BEEF);
    check("t_retry", 32'(retry_cnt), 32'd14);
    check("t_power", 32'(power_value), 32'd15);
    check("t_is_top", {31'h0, is_top}, 32'h1);
    check("t_finish", {31'h0, sort_finish}, 32'h1);

    // ID conflict: ack from die 5 while die 2 is expected
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick(2);
    rx(1'b1, 32'h0005BEEF);
    tick();
    rx(1'b0, 32'h0);
    check("c_fail", {31'h0, sort_fail}, 32'h1);
    check("c_finish", {31'h0, sort_finish}, 32'h0);
    rx(1'b1, 32'h0002BEEF);
    tick(3);
    rx(1'b0, 32'h0);
    check("c_fail_sticky", {31'h0, sort_fail}, 32'h1);

    // Invalid assigned IDs: all-ones and zero
    restart = 1'b1;
    f_layer = 1'b0;
    tick();
    restart = 1'b0;
    tick();
    rx(1'b1, 32'h00F0BEEF);
    tick();
    rx(1'b0, 32'h0);
    check("f_fail", {31'h0, sort_fail}, 32'h1);
    check("f_chip_id", 32'(chip_id), 32'hF);
    check("f_tx", {31'h0, bus.tx_valid}, 32'h0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    rx(1'b1, 32'h0000BEEF);
    tick();
    rx(1'b0, 32'h0);
    check("z_fail", {31'h0, sort_fail}, 32'h1);

    // Async reset mid WAIT_ACK, then clean re-enumeration
    restart = 1'b1;
    f_layer = 1'b1;
    tick();
    restart = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    tick();
    check("midrst_hold_tx", {31'h0, bus.tx_valid}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("re_frame", bus.data_out, 32'hA121BEEF);
    tick();
    rx(1'b1, 32'h0002BEEF);
    tick();
    rx(1'b0, 32'h0);
    check("re_finish", {31'h0, sort_finish}, 32'h1);
    check("re_power", 32'(power_value), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_id_enum.md
STACK_ID_ENUM -- requirements
Module: stack_id_enum

Interface
REQ-001 Parameter ID_W, default 4, chip-ID field width.
REQ-002 Parameter PWR_W, default 4, power-level width; max level is 2^PWR_W-1.
REQ-003 Parameter DATA_W, default 32, frame width; SHALL be at least 20+2*ID_W+PWR_W.
REQ-004 Parameter TIMEOUT, default 20, ack-wait cycles per attempt, range 1..255.
REQ-005 Parameter SYNC, default 16'hBEEF, frame sync word.
REQ-006 One clock, div_8_clk; reset is asynchronous and active-low, rst_n.
REQ-007 div_8_clk  in  1  block clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 f_layer  in  1  high on the bottom (first) die of the stack; quasi-static.
REQ-010 restart  in  1  synchronous re-enumeration request.
REQ-011 rx_valid  in  1  data_in qualifier.
REQ-012 data_in  in  DATA_W  received frame.
REQ-013 tx_ready  in  1  link accepts data_out this cycle.
REQ-014 tx_valid  out  1  data_out valid.
REQ-015 data_out  out  DATA_W  transmitted frame.
REQ-016 chip_id  out  ID_W  assigned die ID.
REQ-017 power_value  out  PWR_W  current TSV drive level.
REQ-018 retry_cnt  out  PWR_W  count of timed-out attempts.
REQ-019 sort_finish, is_top, sort_fail  out  1 each  done, top-die and failure flags.

Function
REQ-020 Frame fields: [15:0] sync, [16+:ID_W] src ID, [16+ID_W+:ID_W] dst ID, [16+2*ID_W+:PWR_W] power, next 4 bits 4'hA, remaining bits 0.
REQ-021 A frame matches only when rx_valid=1 and data_in[15:0]==SYNC.
REQ-022 States: IDLE, RX_ID, TX, WAIT_ACK, DONE, FAIL.
REQ-023 IDLE: f_layer=1 -> chip_id=1, go to TX; f_layer=0 -> go to RX_ID.
REQ-024 RX_ID: on a matching frame -> chip_id=dst ID; if dst ID is 0 or all-ones -> FAIL, else -> TX. Otherwise stay.
REQ-025 power_value SHALL increment by 1, saturating at max, on every transition into TX, including the first.
REQ-026 TX: tx_valid=1; data_out={0,4'hA,power_value,chip_id+1,chip_id,SYNC} laid out per REQ-020; data_out held stable until tx_ready=1, then -> WAIT_ACK with the timer cleared.
REQ-027 tx_valid SHALL be 0 and data_out all-zero in every state other than TX.
REQ-028 WAIT_ACK, matching frame with src ID == chip_id+1 -> DONE, is_top=0.
REQ-029 WAIT_ACK, matching frame with any other src ID -> FAIL (ID conflict).
REQ-030 WAIT_ACK, timer reaches TIMEOUT-1 with no match: power_value at max -> DONE, is_top=1; otherwise retry_cnt+1 (saturating) -> TX.
REQ-031 A matching frame in the same cycle as timeout SHALL take priority over the timeout.
REQ-032 chip_id+1 SHALL be computed in ID_W bits; chip_id all-ones entering TX -> FAIL instead (ID overflow).
REQ-033 DONE and FAIL are terminal except via restart or reset; sort_finish=1 only in DONE; sort_fail=1 only in FAIL.
REQ-034 restart=1 in any state -> IDLE next cycle, clearing chip_id, power_value, retry_cnt and is_top; restart overrides all other events.
REQ-035 rx_valid SHALL be ignored in IDLE, TX, DONE and FAIL; tx_ready SHALL be ignored outside TX.

Reset
REQ-036 rst_n low SHALL immediately force: state IDLE, timer 0, chip_id 0, power_value 0, retry_cnt 0, all flags 0, tx_valid 0, data_out 0.
REQ-037 Reset asserted mid-operation SHALL abort without emitting a partial frame; enumeration restarts from IDLE after release.

Structure
REQ-038 Package stack_id_pkg SHALL hold the state enumeration, the header constant 4'hA and the frame field offset functions.
REQ-039 Sub-module stack_id_timer SHALL implement the clearable WAIT_ACK cycle counter, $clog2(TIMEOUT+1) bits wide, with a terminal-count output.

Verification
REQ-040 f_layer=1, tx_ready=1, ack src=2 on the 3rd WAIT_ACK cycle -> chip_id=1, power_value=1, frame 32'hA1_21_BEEF, sort_finish=1, is_top=0.
REQ-041 f_layer=0, rx frame dst=3 -> chip_id=3, TX frame src=3, dst=4; ack src=4 -> DONE.
REQ-042 f_layer=1, never ack -> 15 TX attempts each TIMEOUT=20 cycles apart, retry_cnt=14, power_value=15, then DONE with is_top=1.
REQ-043 In WAIT_ACK, ack src=5 while chip_id=1 -> sort_fail=1; rx dst=4'hF -> FAIL.
REQ-044 tx_ready held low 7 cycles -> data_out stable, no timer advance; ack and timeout coincident -> DONE with is_top=0.
REQ-045 rst_n pulse in WAIT_ACK and restart in DONE -> all outputs 0 per REQ-036 and REQ-034, re-enumeration succeeds.
